// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the divide sequencer
package div_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_e;
    localparam logic [31:0] ZERO32 = 32'd0;
endpackage

// File: rtl/div_if.sv
// div_if: EX-stage request/stall, divider IP beat/result and HI/LO write bundle
//   master: the div_ctrl side (drives stall, divider operands, HI/LO write)
//   slave : the pipeline + divider IP side
interface div_if;
    logic        ex_div_req;
    logic        ex_div_sign;
    logic [31:0] ex_dividend;
    logic [31:0] ex_divisor;
    logic        flush;
    logic        stall_req;
    logic        div_tvalid;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [63:0] div_dout;
    logic        div_dout_valid;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    modport master (
        input  ex_div_req, ex_div_sign, ex_dividend, ex_divisor, flush, div_dout, div_dout_valid,
        output stall_req, div_tvalid, div_dividend, div_divisor, hilo_we, hi_o, lo_o
    );
    modport slave (
        output ex_div_req, ex_div_sign, ex_dividend, ex_divisor, flush, div_dout, div_dout_valid,
        input  stall_req, div_tvalid, div_dividend, div_divisor, hilo_we, hi_o, lo_o
    );
endinterface

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negation of a pair of 32-bit words
//   a_i/b_i in, neg_a_i/neg_b_i select negation, a_o/b_o out (modulo 2^32)
module div_sign_fix
    import div_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        neg_a_i,
    input  logic        neg_b_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o
);
    assign a_o = neg_a_i ? ZERO32 - a_i : a_i;
    assign b_o = neg_b_i ? ZERO32 - b_i : b_i;
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer owning the pipelined unsigned divider for DIV/DIVU
//   clk, resetn (async active-low), bus: div_if.master carrying EX request/stall,
//   divider beat (div_tvalid, magnitudes) and result, and the HI/LO write strobe
module div_ctrl
    import div_pkg::*;
(
    input logic   clk,
    input logic   resetn,
    div_if.master bus
);
    state_e      state_q, state_d;
    logic [31:0] dividend_q, dividend_d, divisor_q, divisor_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        negq_q, negq_d, negr_q, negr_d;
    logic [31:0] mag_a, mag_b, fix_quo, fix_rem;
    logic        sgn_a, sgn_b, accept;

    assign sgn_a  = bus.ex_div_sign & bus.ex_dividend[31];
    assign sgn_b  = bus.ex_div_sign & bus.ex_divisor[31];
    assign accept = bus.ex_div_req & !bus.flush;

    div_sign_fix u_op (
        .a_i(bus.ex_dividend), .b_i(bus.ex_divisor), .neg_a_i(sgn_a), .neg_b_i(sgn_b),
        .a_o(mag_a), .b_o(mag_b)
    );

    div_sign_fix u_res (
        .a_i(bus.div_dout[63:32]), .b_i(bus.div_dout[31:0]), .neg_a_i(negq_q), .neg_b_i(negr_q),
        .a_o(fix_quo), .b_o(fix_rem)
    );

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        case (state_q)
            IDLE: if (accept) begin
                dividend_d = mag_a;
                divisor_d  = mag_b;
                negq_d     = sgn_a ^ sgn_b;
                negr_d     = sgn_a;
                // A zero operand never reaches the IP; the result is known to be 0/0
                if (bus.ex_dividend == ZERO32 || bus.ex_divisor == ZERO32) begin
                    hi_d    = ZERO32;
                    lo_d    = ZERO32;
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = bus.flush ? IDLE : WAIT;
            WAIT: if (bus.div_dout_valid) begin
                state_d = bus.flush ? IDLE : DONE;
                hi_d    = bus.flush ? hi_q : fix_rem;
                lo_d    = bus.flush ? lo_q : fix_quo;
            end else if (bus.flush) begin
                state_d = DRAIN;
            end
            DONE:    state_d = IDLE;
            DRAIN:   state_d = bus.div_dout_valid ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            dividend_q <= ZERO32;
            divisor_q  <= ZERO32;
            hi_q       <= ZERO32;
            lo_q       <= ZERO32;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
        end
    end

    // resetn gates the stall so every output reads 0 while reset is held
    assign bus.stall_req    = resetn & ((state_q == IDLE && accept) || state_q == ISSUE ||
                                        state_q == WAIT || (state_q == DRAIN && bus.ex_div_req));
    assign bus.div_tvalid   = state_q == ISSUE && !bus.flush;
    assign bus.hilo_we      = state_q == DONE && !bus.flush;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.hi_o         = hi_q;
    assign bus.lo_o         = lo_q;
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer in the EX stage that owns the pipelined 32/32 unsigned divider IP on behalf of DIV/DIVU instructions. It converts signed operands to magnitudes, issues exactly one operand beat per instruction, and stalls the pipeline while the divide is in flight. It restores signs on the result, writes HI (remainder) and LO (quotient), and discards results belonging to instructions cancelled by an exception flush.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- ex_div_req  in  1  EX holds a valid DIV/DIVU; held high until stall_req drops
- ex_div_sign  in  1  1 = DIV (signed), 0 = DIVU
- ex_dividend  in  32  rs operand
- ex_divisor  in  32  rt operand
- flush  in  1  exception/ERET flush; cancels the current instruction
- stall_req  out  1  freeze IF–EX
- div_tvalid  out  1  drives both divider s_axis tvalid inputs
- div_dividend  out  32  registered dividend magnitude
- div_divisor  out  32  registered divisor magnitude
- div_dout  in  64  {quotient[63:32], remainder[31:0]}, unsigned
- div_dout_valid  in  1  one-cycle result strobe
- hilo_we  out  1  one-cycle write strobe to HI/LO
- hi_o  out  32  signed-corrected remainder
- lo_o  out  32  signed-corrected quotient

Reset values: state IDLE; all outputs 0.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE, ex_div_req & !flush:
  - Latch magnitudes: a negative operand is negated when the sign bit is set and ex_div_sign=1.
  - Latch neg_q = sign & (dividend[31] ^ divisor[31]) and neg_r = sign & dividend[31].
  - Divisor == 0 or dividend == 0: bypass the IP, go to DONE with hi/lo = 0.
  - Otherwise go to ISSUE.
- ISSUE: div_tvalid = !flush, for one cycle only.
  - flush=0: go to WAIT.
  - flush=1: no beat is sent; go to IDLE.
- WAIT: on div_dout_valid, capture the corrected result and go to DONE.
  - Correction: lo = neg_q ? -q : q; hi = neg_r ? -r : r. All arithmetic is modulo 2^32.
  - flush without div_dout_valid: go to DRAIN.
  - flush with div_dout_valid in the same cycle: discard the result and go to IDLE.
- DONE: hilo_we = !flush; go to IDLE unconditionally.
- DRAIN: wait for div_dout_valid, discard it, then go to IDLE.
  - A new ex_div_req is held off; it is not latched in DRAIN.
- stall_req = (IDLE & ex_div_req & !flush) | ISSUE | WAIT | (DRAIN & ex_div_req).
  - stall_req is low in DONE, so EX advances in the same cycle that hilo_we fires.
- The IP is never cancelled. At most one beat is outstanding at any time.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: ISSUE, div_tvalid high. Cycles 2..1+L: WAIT, where L is the IP latency from tvalid to dout_valid.
- The cycle after dout_valid is DONE: hilo_we = 1, stall_req = 0.
- Total stall = L + 2 cycles. The zero-operand bypass stalls exactly 1 cycle.
- hi_o/lo_o are registered. They are valid with hilo_we and hold until the next capture.
- div_dividend/div_divisor are stable from ISSUE until the next IDLE latch.
- Back-to-back divides: the next request is accepted in the IDLE cycle following DONE.
- resetn asserted mid-operation: return to IDLE immediately and clear all outputs.
  - A late dout_valid arriving after reset, while in IDLE, is ignored.

## Structure
- Shared package div_pkg: state enum encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3, DRAIN=4) and a ZERO32 constant.
- Sub-module div_sign_fix: combinational magnitude conversion and result negation from neg_q/neg_r. Instantiate it twice: once for operands, once for the result.
- The controller FSM plus registers is one module. The divider IP is instantiated by the parent, not inside this block.

## Test plan
Bench divider model: unsigned, fixed latency L = 36.
- DIVU 100/7 → stall_req high for 38 cycles; hilo_we with lo = 14, hi = 2; div_tvalid pulsed exactly once.
- DIV -7/2 → div_dividend = 7; lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1).
- DIV 0x80000000/0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIV 5/0 → no div_tvalid; DONE the next cycle with hi = lo = 0; total stall 1 cycle.
- flush 10 cycles into WAIT → DRAIN; a second DIV request stays stalled until the stale dout_valid arrives; no hilo_we for the first divide; the second divide then completes normally.
- flush during ISSUE → div_tvalid stays 0, return to IDLE. resetn low during WAIT → all outputs 0; the later dout_valid produces no hilo_we.
